johnson_checker: RTL

Receive-side companion to the `jcnt` Johnson counter. The block samples an N-bit Johnson code word each qualified cycle and decodes it to a binary phase index. It also flags illegal code words and out-of-order transitions, tracks sequence lock, and keeps a saturating error count. It sits downstream of any Johnson-coded counter or ring as a decoder and integrity monitor.

---
 rtl/johnson_pkg.sv | 20 ++
 rtl/johnson_decode.sv | 36 +++
 rtl/johnson_checker.sv | 133 +++++++++++++
 3 files changed

// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson-code checker: FSM states,
// index-width helper and the phase successor function.
package johnson_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_TRACKING = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  function automatic int idx_width(input int n);
    return $clog2(2 * n);
  endfunction

  // Phase after i in a 2n-state Johnson sequence; wraps 2n-1 -> 0.
  function automatic int unsigned succ_idx(input int unsigned i, input int unsigned n);
    return (i + 1 == 2 * n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson code word decoder: legality test and phase index.
module johnson_decode
  import johnson_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     q,
  output logic [IDX_W-1:0] idx,
  output logic             legal
);

  // One extra bit so that 2N itself is representable.
  localparam logic [IDX_W:0] SPAN = (IDX_W + 1)'(2 * N);

  logic [IDX_W:0] ones;
  logic [IDX_W:0] trans;
  logic [IDX_W:0] idx_full;

  always_comb begin
    ones  = '0;
    trans = '0;
    for (int i = 0; i < N; i++) begin
      ones = ones + {{IDX_W{1'b0}}, q[i]};
    end
    for (int i = 0; i < N - 1; i++) begin
      trans = trans + {{IDX_W{1'b0}}, q[i] ^ q[i+1]};
    end
  end

  // Upper half of the sequence counts ones back down from 2N.
  assign idx_full = q[N-1] ? (SPAN - ones) : ones;
  assign idx      = idx_full[IDX_W-1:0];
  assign legal    = (trans <= (IDX_W + 1)'(1));

endmodule

// File: rtl/johnson_checker.sv
// Johnson code decoder and integrity monitor: decodes phase, flags illegal
// words and out-of-order steps, tracks lock and counts errors.
module johnson_checker
  import johnson_pkg::*;
#(
  parameter int N        = 4,
  parameter int ERR_W    = 8,
  parameter int LOCK_CNT = 4,
  localparam int IDX_W   = idx_width(N),
  localparam int RUN_W   = $clog2(LOCK_CNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [N-1:0]     q,
  input  logic             err_clr,
  output logic [IDX_W-1:0] idx,
  output logic             idx_valid,
  output logic             illegal,
  output logic             seq_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt,
  output state_t           fsm_state
);

  // valid qualifies q for one cycle; there is no backpressure, every valid
  // cycle is consumed and answered one cycle later.

  localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_CNT);

  state_t           state, state_next;
  logic [RUN_W-1:0] run, run_next;
  logic [IDX_W-1:0] dec_idx, succ, idx_next;
  logic             dec_legal;
  logic             in_order, stall;
  logic             idx_valid_next, illegal_next, seq_err_next, err;
  logic [ERR_W-1:0] err_cnt_next;

  johnson_decode #(.N(N), .IDX_W(IDX_W)) u_decode (
    .q     (q),
    .idx   (dec_idx),
    .legal (dec_legal)
  );

  assign succ     = IDX_W'(succ_idx(32'(idx), 32'(N)));
  assign in_order = (dec_idx == succ);
  assign stall    = (dec_idx == idx);

  always_comb begin
    state_next     = state;
    run_next       = run;
    idx_next       = idx;
    idx_valid_next = 1'b0;
    illegal_next   = 1'b0;
    seq_err_next   = 1'b0;
    if (valid) begin
      if (!dec_legal) begin
        illegal_next = 1'b1;
        state_next   = ST_UNLOCKED;
        run_next     = '0;
      end else begin
        idx_next       = dec_idx;
        idx_valid_next = 1'b1;
        case (state)
          ST_UNLOCKED: begin
            state_next = ST_TRACKING;
            run_next   = RUN_W'(1);
          end
          ST_TRACKING: begin
            if (in_order) begin
              run_next = run + RUN_W'(1);
              if (run + RUN_W'(1) >= RUN_LOCK) begin
                run_next   = RUN_LOCK;
                state_next = ST_LOCKED;
              end
            end else if (!stall) begin
              seq_err_next = 1'b1;
              run_next     = RUN_W'(1);
            end
          end
          ST_LOCKED: begin
            if (!in_order && !stall) begin
              seq_err_next = 1'b1;
              state_next   = ST_TRACKING;
              run_next     = RUN_W'(1);
            end
          end
          default: begin
            state_next = ST_UNLOCKED;
            run_next   = '0;
          end
        endcase
      end
    end
  end

  // A clear wins over accumulation but still records a coincident error.
  assign err = illegal_next | seq_err_next;

  always_comb begin
    err_cnt_next = err_cnt;
    if (err_clr) begin
      err_cnt_next = err ? ERR_W'(1) : '0;
    end else if (err && (err_cnt != {ERR_W{1'b1}})) begin
      err_cnt_next = err_cnt + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_UNLOCKED;
      run       <= '0;
      idx       <= '0;
      idx_valid <= 1'b0;
      illegal   <= 1'b0;
      seq_err   <= 1'b0;
      locked    <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_next;
      run       <= run_next;
      idx       <= idx_next;
      idx_valid <= idx_valid_next;
      illegal   <= illegal_next;
      seq_err   <= seq_err_next;
      locked    <= (state_next == ST_LOCKED);
      err_cnt   <= err_cnt_next;
    end
  end

  assign fsm_state = state;

endmodule
